q88_pow_ctrl: RTL

- Sequencer and shift-add multiplier that computes Y = A^N in Q8.8 by right-to-left square-and-multiply.
- Drives the load/init/enable ports of the existing R (accumulated result), T (running power) and N (remaining exponent) registers, and reads their outputs back.
- Sits directly upstream of those registers. Presents a start/busy/done interface to the system controller.

---
 rtl/q88_pow_ctrl_if.sv | 36 +++
 rtl/q88_pow_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/q88_pow_ctrl_if.sv
// Handshake and register-port bundle for the Q8.8 power sequencer.
// slave is the sequencer side; master is the system controller plus the R/T/N registers.
interface q88_pow_ctrl_if #(
  parameter int W  = 16,
  parameter int NW = 4
);
  logic          start;
  logic [W-1:0]  base;
  logic [NW-1:0] exp;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          ovf;
  logic          reg_init;
  logic          r_load_en;
  logic          t_load_en;
  logic          n_load_en;
  logic [W-1:0]  r_load;
  logic [W-1:0]  t_load;
  logic [NW-1:0] n_load;
  logic [W-1:0]  r_q;
  logic [W-1:0]  t_q;
  logic [NW-1:0] n_q;

  modport slave (
    input  start, base, exp, r_q, t_q, n_q,
    output busy, done, result, ovf, reg_init,
           r_load_en, t_load_en, n_load_en, r_load, t_load, n_load
  );

  modport master (
    output start, base, exp, r_q, t_q, n_q,
    input  busy, done, result, ovf, reg_init,
           r_load_en, t_load_en, n_load_en, r_load, t_load, n_load
  );
endinterface

// File: rtl/q88_pow_ctrl.sv
// Q8.8 A^N by right-to-left square-and-multiply over external R/T/N registers; done 4 cycles after accept
// for N=0, +2 per loop iteration, +17 per multiply; start ignored while busy. Q88_ROUND_EN: round half up, else truncate.
module q88_pow_ctrl #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int NW   = 4
) (
  input logic            clk,
  input logic            rst,
  q88_pow_ctrl_if.slave  bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [3:0] {
    IDLE, INIT, LOADT, CHECK, MUL_RT, WR_R, MUL_TT, WR_T, SHIFT, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      base_q, base_d;
  logic [NW-1:0]     exp_q, exp_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [2*W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [W-1:0]      result_q, result_d;

  logic              mul_go;
  logic              mul_sel_r;
  logic [2*W-1:0]    prod_adj;
  logic [2*W-1:0]    prod_shift;
  logic [W-1:0]      mul_out;
  logic              mul_sat;

  logic              busy_o, done_o, reg_init_o;
  logic              r_load_en_o, t_load_en_o, n_load_en_o;
  logic [W-1:0]      result_o, r_load_o, t_load_o;
  logic [NW-1:0]     n_load_o;

`ifdef Q88_ROUND_EN
  localparam logic [2*W-1:0] RND = (2*W)'(1) << (FRAC - 1);
  assign prod_adj = acc_q + RND;
`else
  assign prod_adj = acc_q;
`endif

  // Anything left above the Q8.8 window after dropping FRAC bits means the value does not fit.
  assign prod_shift = prod_adj >> FRAC;
  assign mul_sat    = |prod_shift[2*W-1:W];
  assign mul_out    = mul_sat ? {W{1'b1}} : prod_shift[W-1:0];

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    result_d  = result_q;

    busy_o      = (state_q != IDLE);
    done_o      = 1'b0;
    result_o    = result_q;
    reg_init_o  = 1'b0;
    r_load_en_o = 1'b0;
    t_load_en_o = 1'b0;
    n_load_en_o = 1'b0;
    r_load_o    = '0;
    t_load_o    = '0;
    n_load_o    = '0;
    mul_go      = 1'b0;
    mul_sel_r   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = INIT;
          base_d   = bus.base;
          exp_d    = bus.exp;
          ovf_d    = 1'b0;
          result_d = '0;
        end
      end
      INIT: begin
        reg_init_o  = 1'b1;
        n_load_en_o = 1'b1;
        n_load_o    = exp_q;
        state_d     = LOADT;
      end
      LOADT: begin
        t_load_en_o = 1'b1;
        t_load_o    = base_q;
        state_d     = CHECK;
      end
      CHECK: begin
        if (bus.n_q == '0) begin
          state_d = DONE;
        end else if (bus.n_q[0]) begin
          state_d   = MUL_RT;
          mul_go    = 1'b1;
          mul_sel_r = 1'b1;
        end else if (|bus.n_q[NW-1:1]) begin
          state_d = MUL_TT;
          mul_go  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      MUL_RT, MUL_TT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = (state_q == MUL_RT) ? WR_R : WR_T;
      end
      WR_R: begin
        r_load_en_o = 1'b1;
        r_load_o    = mul_out;
        if (mul_sat) ovf_d = 1'b1;
        // No square on the last exponent bit: T would never be read again.
        if (|bus.n_q[NW-1:1]) begin
          state_d = MUL_TT;
          mul_go  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      WR_T: begin
        t_load_en_o = 1'b1;
        t_load_o    = mul_out;
        if (mul_sat) ovf_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        n_load_en_o = 1'b1;
        n_load_o    = bus.n_q >> 1;
        state_d     = CHECK;
      end
      DONE: begin
        done_o   = 1'b1;
        result_o = bus.r_q;
        result_d = bus.r_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // T is the multiplier for both products; the multiplicand picks R or T.
    if (mul_go) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, (mul_sel_r ? bus.r_q : bus.t_q)};
      mplier_d = bus.t_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.result    = result_o;
  assign bus.ovf       = ovf_q;
  assign bus.reg_init  = reg_init_o;
  assign bus.r_load_en = r_load_en_o;
  assign bus.t_load_en = t_load_en_o;
  assign bus.n_load_en = n_load_en_o;
  assign bus.r_load    = r_load_o;
  assign bus.t_load    = t_load_o;
  assign bus.n_load    = n_load_o;

endmodule
